// File: rtl/seq_pattern_detector.sv
// ----------------------------------------------------------------------------
// seq_pattern_detector
//
// Moore-style serial pattern detector. Qualified bits (j sampled only when
// j_valid=1) shift into a PAT_W-bit history register. When PAT_W bits have
// been collected and the history equals the pattern, a one-cycle registered
// pulse is raised on w and a saturating counter is incremented. Detection may
// be overlapping (a match keeps the history armed) or non-overlapping (a match
// restarts collection from zero bits), chosen per edge by overlap_en.
//
// Parameters:
//   PAT_W    pattern length in bits (2..32)
//   PATTERN  reset/default pattern, MSB is the first bit received
//   CNT_W    width of match_cnt, saturates at 2^CNT_W-1
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   j          serial data bit
//   j_valid    qualifies j on the current edge
//   overlap_en 1 = overlapping detection, 0 = non-overlapping
//   clr_cnt    synchronous clear of match_cnt (wins over a same-edge match)
//   pat_load   (SEQ_PATTERN_LOAD_EN only) load pat_in as the new pattern
//   pat_in     (SEQ_PATTERN_LOAD_EN only) pattern value to load
//   w          registered one-cycle match pulse
//   match_cnt  saturating count of matches
//
// Build option:
//   SEQ_PATTERN_LOAD_EN  adds pat_load/pat_in and a run-time pattern register.
//                        Undefined: the pattern is the constant PATTERN.
// ----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int unsigned      PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             j,
    input  logic             j_valid,
    input  logic             overlap_en,
    input  logic             clr_cnt,
`ifdef SEQ_PATTERN_LOAD_EN
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`endif
    output logic             w,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      FILL_W  = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // FILLING while fewer than PAT_W bits are held; only ARMED can match.
    typedef enum logic {
        FILLING,
        ARMED
    } phase_t;

    logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [PAT_W-1:0]  pat_q;
    logic              load;
    logic              match;
    logic              w_d;
    logic [CNT_W-1:0]  cnt_d;
    phase_t            phase;

    // ------------------------------------------------------------------------
    // Pattern source
    // ------------------------------------------------------------------------
`ifdef SEQ_PATTERN_LOAD_EN
    assign load = pat_load;

    // NOTE: the pattern register resets to PATTERN so the block detects the
    // default pattern without ever being loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PATTERN;
        end else if (pat_load) begin
            pat_q <= pat_in;
        end
    end
`else
    assign load  = 1'b0;
    assign pat_q = PATTERN;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            w         <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            w         <= w_d;
            match_cnt <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    assign phase      = (fill_q == FULL) ? ARMED : FILLING;
    assign hist_shift = {hist_q[PAT_W-2:0], j};
    assign fill_inc   = (phase == ARMED) ? FULL : fill_q + FILL_W'(1);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        match  = 1'b0;
        if (load) begin
            // A load restarts collection; j/j_valid are ignored this edge.
            fill_d = '0;
        end else if (j_valid) begin
            match  = (fill_inc == FULL) && (hist_shift == pat_q);
            hist_d = hist_shift;
            // Non-overlapping: the next match must be built from fresh bits.
            fill_d = (match && !overlap_en) ? '0 : fill_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic (values registered into w / match_cnt)
    // ------------------------------------------------------------------------
    always_comb begin
        w_d   = match;
        cnt_d = match_cnt;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (match_cnt != CNT_MAX)) begin
            cnt_d = match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ----------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Bench for seq_pattern_detector. Two instances share one stimulus stream:
// dut uses the defaults (CNT_W=8), dut2 uses CNT_W=2 to reach saturation.
// Each driven edge pushes its expected w / match_cnt values to exp_q; the
// values observed 1 ns after that edge are pushed to got_q, and each test
// task drains both queues and compares them.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       j = 1'b0;
    logic       j_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       clr_cnt = 1'b0;
    logic       w, w2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
`ifdef SEQ_PATTERN_LOAD_EN
    logic       pat_load = 1'b0;
    logic [4:0] pat_in = 5'b00000;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       w;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        bit         chk2;
        string      tag;
    } rec_t;

    rec_t exp_q[$];
    rec_t got_q[$];

    always #5 clk = ~clk;

    seq_pattern_detector dut (
        .clk        (clk),
        .rst        (rst),
        .j          (j),
        .j_valid    (j_valid),
        .overlap_en (overlap_en),
        .clr_cnt    (clr_cnt),
`ifdef SEQ_PATTERN_LOAD_EN
        .pat_load   (pat_load),
        .pat_in     (pat_in),
`endif
        .w          (w),
        .match_cnt  (match_cnt)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .j          (j),
        .j_valid    (j_valid),
        .overlap_en (overlap_en),
        .clr_cnt    (clr_cnt),
`ifdef SEQ_PATTERN_LOAD_EN
        .pat_load   (pat_load),
        .pat_in     (pat_in),
`endif
        .w          (w2),
        .match_cnt  (match_cnt2)
    );

    // Drive one edge's inputs at the falling edge, record the expectation,
    // then capture the registered outputs 1 ns after the rising edge.
    task automatic drive(input logic jb, input logic jv, input logic ov,
                         input logic clr, input logic ld, input logic [4:0] pin,
                         input logic exp_w, input int exp_cnt, input int exp_cnt2,
                         input string tag);
        rec_t e, g;
        @(negedge clk);
        j          = jb;
        j_valid    = jv;
        overlap_en = ov;
        clr_cnt    = clr;
`ifdef SEQ_PATTERN_LOAD_EN
        pat_load   = ld;
        pat_in     = pin;
`endif
        e.w    = exp_w;
        e.cnt  = 8'(exp_cnt);
        e.cnt2 = 2'(exp_cnt2);
        e.chk2 = (exp_cnt2 >= 0);
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g.w    = w;
        g.cnt  = match_cnt;
        g.cnt2 = match_cnt2;
        g.chk2 = 1'b0;
        g.tag  = tag;
        got_q.push_back(g);
    endtask

    task automatic bit_in(input logic jb, input logic ov, input logic exp_w,
                          input int exp_cnt, input string tag);
        drive(jb, 1'b1, ov, 1'b0, 1'b0, 5'b0, exp_w, exp_cnt, -1, tag);
    endtask

    task automatic idle(input logic jb, input logic exp_w, input int exp_cnt,
                        input string tag);
        drive(jb, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0, exp_w, exp_cnt, -1, tag);
    endtask

    task automatic do_reset();
        j_valid = 1'b0;
        clr_cnt = 1'b0;
`ifdef SEQ_PATTERN_LOAD_EN
        pat_load = 1'b0;
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (w !== 1'b0 || w2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_w: got %b/%b want 0/0", w, w2);
        end
        checks++;
        if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", match_cnt, match_cnt2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        rec_t e, g;
        do_reset();
        bit_in(1'b1, 1'b1, 1'b0, 0, "basic_b1");
        bit_in(1'b0, 1'b1, 1'b0, 0, "basic_b2");
        bit_in(1'b1, 1'b1, 1'b0, 0, "basic_b3");
        bit_in(1'b1, 1'b1, 1'b0, 0, "basic_b4");
        bit_in(1'b0, 1'b1, 1'b1, 1, "basic_b5");
        idle(1'b0, 1'b0, 1, "basic_idle1");
        idle(1'b1, 1'b0, 1, "basic_idle2");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.w !== e.w || g.cnt !== e.cnt || (e.chk2 && g.cnt2 !== e.cnt2)) begin
                errors++;
                $display("FAIL %s: got w=%b cnt=%0d cnt2=%0d want w=%b cnt=%0d cnt2=%0d",
                         e.tag, g.w, g.cnt, g.cnt2, e.w, e.cnt, e.cnt2);
            end
        end
    endtask

    task automatic test_overlap();
        rec_t e, g;
        logic [7:0] s;
        // Stream 1,0,1,1,0,1,1,0 with overlap: matches on bits 5 and 8.
        s = 8'b10110110;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bit_in(s[7-i], 1'b1, (i == 4 || i == 7), (i < 4) ? 0 : (i < 7) ? 1 : 2,
                   $sformatf("ovl_b%0d", i + 1));
        end
        // Same stream without overlap: only bit 5 matches.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bit_in(s[7-i], 1'b0, (i == 4), (i < 4) ? 0 : 1,
                   $sformatf("novl_b%0d", i + 1));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.w !== e.w || g.cnt !== e.cnt || (e.chk2 && g.cnt2 !== e.cnt2)) begin
                errors++;
                $display("FAIL %s: got w=%b cnt=%0d cnt2=%0d want w=%b cnt=%0d cnt2=%0d",
                         e.tag, g.w, g.cnt, g.cnt2, e.w, e.cnt, e.cnt2);
            end
        end
    endtask

    task automatic test_valid_gap();
        rec_t e, g;
        do_reset();
        bit_in(1'b1, 1'b1, 1'b0, 0, "gap_b1");
        bit_in(1'b0, 1'b1, 1'b0, 0, "gap_b2");
        idle(1'b1, 1'b0, 0, "gap_i1");
        idle(1'b0, 1'b0, 0, "gap_i2");
        idle(1'b1, 1'b0, 0, "gap_i3");
        bit_in(1'b1, 1'b1, 1'b0, 0, "gap_b3");
        bit_in(1'b1, 1'b1, 1'b0, 0, "gap_b4");
        bit_in(1'b0, 1'b1, 1'b1, 1, "gap_b5");
        idle(1'b1, 1'b0, 1, "gap_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.w !== e.w || g.cnt !== e.cnt || (e.chk2 && g.cnt2 !== e.cnt2)) begin
                errors++;
                $display("FAIL %s: got w=%b cnt=%0d cnt2=%0d want w=%b cnt=%0d cnt2=%0d",
                         e.tag, g.w, g.cnt, g.cnt2, e.w, e.cnt, e.cnt2);
            end
        end
    endtask

    task automatic test_saturate_clear();
        rec_t e, g;
        logic [4:0] p;
        logic       last, clr;
        int         c8, c2;
        p = 5'b10110;
        do_reset();
        // Five plain matches then a sixth with clr_cnt on its completing edge.
        for (int m = 0; m < 6; m++) begin
            for (int b = 0; b < 5; b++) begin
                last = (b == 4);
                clr  = (m == 5) && last;
                c8   = last ? m + 1 : m;
                c2   = (c8 > 3) ? 3 : c8;
                if (clr) begin
                    c8 = 0;
                    c2 = 0;
                end
                drive(p[4-b], 1'b1, 1'b0, clr, 1'b0, 5'b0, last, c8, c2,
                      $sformatf("sat_m%0d_b%0d", m + 1, b + 1));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 0, 0, "sat_after_clr");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.w !== e.w || g.cnt !== e.cnt || (e.chk2 && g.cnt2 !== e.cnt2)) begin
                errors++;
                $display("FAIL %s: got w=%b cnt=%0d cnt2=%0d want w=%b cnt=%0d cnt2=%0d",
                         e.tag, g.w, g.cnt, g.cnt2, e.w, e.cnt, e.cnt2);
            end
        end
    endtask

    task automatic test_mid_reset();
        rec_t e, g;
        do_reset();
        bit_in(1'b1, 1'b1, 1'b0, 0, "mrst_b1");
        bit_in(1'b0, 1'b1, 1'b0, 0, "mrst_b2");
        bit_in(1'b1, 1'b1, 1'b0, 0, "mrst_b3");
        bit_in(1'b1, 1'b1, 1'b0, 0, "mrst_b4");
        // Pulse reset between clock edges; the partial 1,0,1,1 is lost.
        #1 rst = 1'b0;
        #1;
        checks++;
        if (w !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL mrst_async: got w=%b cnt=%0d want w=0 cnt=0", w, match_cnt);
        end
        #1 rst = 1'b1;
        bit_in(1'b0, 1'b1, 1'b0, 0, "mrst_tail0");
        bit_in(1'b1, 1'b1, 1'b0, 0, "mrst_n1");
        bit_in(1'b0, 1'b1, 1'b0, 0, "mrst_n2");
        bit_in(1'b1, 1'b1, 1'b0, 0, "mrst_n3");
        bit_in(1'b1, 1'b1, 1'b0, 0, "mrst_n4");
        bit_in(1'b0, 1'b1, 1'b1, 1, "mrst_n5");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.w !== e.w || g.cnt !== e.cnt || (e.chk2 && g.cnt2 !== e.cnt2)) begin
                errors++;
                $display("FAIL %s: got w=%b cnt=%0d cnt2=%0d want w=%b cnt=%0d cnt2=%0d",
                         e.tag, g.w, g.cnt, g.cnt2, e.w, e.cnt, e.cnt2);
            end
        end
    endtask

`ifdef SEQ_PATTERN_LOAD_EN
    task automatic test_pat_load();
        rec_t e, g;
        logic [9:0] s;
        do_reset();
        bit_in(1'b1, 1'b1, 1'b0, 0, "load_pre1");
        bit_in(1'b0, 1'b1, 1'b0, 0, "load_pre2");
        // j/j_valid are active on the load edge but must be ignored.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00111, 1'b0, 0, -1, "load_edge");
        s = 10'b00111_10110;
        for (int i = 0; i < 10; i++) begin
            bit_in(s[9-i], 1'b1, (i == 4), (i < 4) ? 0 : 1,
                   $sformatf("load_s%0d", i + 1));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g.w !== e.w || g.cnt !== e.cnt || (e.chk2 && g.cnt2 !== e.cnt2)) begin
                errors++;
                $display("FAIL %s: got w=%b cnt=%0d cnt2=%0d want w=%b cnt=%0d cnt2=%0d",
                         e.tag, g.w, g.cnt, g.cnt2, e.w, e.cnt, e.cnt2);
            end
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_valid_gap();
        test_saturate_clear();
        test_mid_reset();
`ifdef SEQ_PATTERN_LOAD_EN
        test_pat_load();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
